rs_dispatch_sel: RTL and testbench

//  Select/dispatch stage directly downstream of the centralized reservation station (RS).

---
 rtl/rs_dispatch_sel_if.sv | 42 ++++
 rtl/rs_dispatch_sel.sv | 138 +++++++++++++
 tb/tb_rs_dispatch_sel.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_dispatch_sel_if.sv
// rtl/rs_dispatch_sel_if.sv - RS-to-dispatch-to-EU bundle for rs_dispatch_sel (optional RS_DSP_STALL_CNT_EN)
interface rs_dispatch_sel_if #(
    parameter int RS_NUM_ENTRIES = 16,
    parameter int NUM_LANES      = 4,
    parameter int LANE_CLOG      = 2,
    parameter int ROB_SIZE_CLOG  = 5,
    parameter int OP_LEN         = 6,
    parameter int DATA_LEN       = 32
);
    logic                                             flush;
    logic [RS_NUM_ENTRIES-1:0]                        alloc_ety;
    logic [RS_NUM_ENTRIES-1:0]                        ety_rdy;
    logic [RS_NUM_ENTRIES-1:0][LANE_CLOG-1:0]         ety_fu;
    logic [RS_NUM_ENTRIES-1:0][OP_LEN-1:0]            ety_op;
    logic [RS_NUM_ENTRIES-1:0][ROB_SIZE_CLOG-1:0]     ety_robid;
    logic [RS_NUM_ENTRIES-1:0][1:0][DATA_LEN-1:0]     ety_v;
    logic [NUM_LANES-1:0]                             eu_rdy;
    logic [NUM_LANES-1:0]                             dsp_val;
    logic [NUM_LANES-1:0][OP_LEN-1:0]                 dsp_op;
    logic [NUM_LANES-1:0][ROB_SIZE_CLOG-1:0]          dsp_robid;
    logic [NUM_LANES-1:0][1:0][DATA_LEN-1:0]          dsp_src;
    logic [NUM_LANES-1:0][RS_NUM_ENTRIES-1:0]         rs_free_ety;
`ifdef RS_DSP_STALL_CNT_EN
    logic [NUM_LANES-1:0][15:0]                       dsp_stall_cnt;
`endif

    modport master (
`ifdef RS_DSP_STALL_CNT_EN
        input  dsp_stall_cnt,
`endif
        output flush, alloc_ety, ety_rdy, ety_fu, ety_op, ety_robid, ety_v, eu_rdy,
        input  dsp_val, dsp_op, dsp_robid, dsp_src, rs_free_ety
    );

    modport slave (
`ifdef RS_DSP_STALL_CNT_EN
        output dsp_stall_cnt,
`endif
        input  flush, alloc_ety, ety_rdy, ety_fu, ety_op, ety_robid, ety_v, eu_rdy,
        output dsp_val, dsp_op, dsp_robid, dsp_src, rs_free_ety
    );
endinterface

// File: rtl/rs_dispatch_sel.sv
// rtl/rs_dispatch_sel.sv - oldest-ready per-lane select and dispatch register after the RS (optional RS_DSP_STALL_CNT_EN)
module rs_dispatch_sel #(
    parameter int RS_NUM_ENTRIES = 16,
    parameter int NUM_LANES      = 4,
    parameter int LANE_CLOG      = 2,
    parameter int ROB_SIZE_CLOG  = 5,
    parameter int OP_LEN         = 6,
    parameter int DATA_LEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    rs_dispatch_sel_if.slave  dif
);
    localparam int N = RS_NUM_ENTRIES;
    localparam int L = NUM_LANES;

    logic [N-1:0][N-1:0]                older;
    logic [N-1:0][N-1:0]                older_col;
    logic [L-1:0][N-1:0]                cand;
    logic [L-1:0][N-1:0]                oldest;
    logic [L-1:0][N-1:0]                pick;
    logic [L-1:0]                       lane_open;
    logic [L-1:0]                       lane_go;
    logic [L-1:0][OP_LEN-1:0]           nxt_op;
    logic [L-1:0][ROB_SIZE_CLOG-1:0]    nxt_robid;
    logic [L-1:0][1:0][DATA_LEN-1:0]    nxt_src;

    logic [L-1:0]                       dsp_val_q;
    logic [L-1:0][OP_LEN-1:0]           dsp_op_q;
    logic [L-1:0][ROB_SIZE_CLOG-1:0]    dsp_robid_q;
    logic [L-1:0][1:0][DATA_LEN-1:0]    dsp_src_q;

    always_comb begin
        older_col = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                older_col[i][j] = older[j][i];
            end
        end
    end

    // Entries never allocated since reset carry no ordering; the lowest-index
    // survivor is taken so that a lane never frees more than one entry.
    always_comb begin
        cand      = '0;
        oldest    = '0;
        pick      = '0;
        lane_open = '0;
        lane_go   = '0;
        nxt_op    = '0;
        nxt_robid = '0;
        nxt_src   = '0;
        for (int l = 0; l < L; l++) begin
            lane_open[l] = ~dsp_val_q[l] | dif.eu_rdy[l];
            for (int i = 0; i < N; i++) begin
                cand[l][i] = dif.ety_rdy[i] & ~dif.alloc_ety[i] & (dif.ety_fu[i] == LANE_CLOG'(l));
            end
            for (int i = 0; i < N; i++) begin
                oldest[l][i] = cand[l][i] & ~|(cand[l] & older_col[i]);
            end
            pick[l]    = oldest[l] & (~oldest[l] + N'(1));
            lane_go[l] = lane_open[l] & (|pick[l]) & ~dif.flush & rst;
            for (int i = 0; i < N; i++) begin
                if (pick[l][i]) begin
                    nxt_op[l]    = nxt_op[l]    | dif.ety_op[i];
                    nxt_robid[l] = nxt_robid[l] | dif.ety_robid[i];
                    nxt_src[l]   = nxt_src[l]   | dif.ety_v[i];
                end
            end
        end
    end

    always_comb begin
        dif.rs_free_ety = '0;
        for (int l = 0; l < L; l++) begin
            if (lane_go[l]) begin
                dif.rs_free_ety[l] = pick[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            older       <= '0;
            dsp_val_q   <= '0;
            dsp_op_q    <= '0;
            dsp_robid_q <= '0;
            dsp_src_q   <= '0;
        end else begin
            if (!dif.flush) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (dif.alloc_ety[i]) begin
                            older[i][j] <= dif.alloc_ety[j] && (j > i);
                        end else if (dif.alloc_ety[j]) begin
                            older[i][j] <= 1'b1;
                        end
                    end
                end
            end
            for (int l = 0; l < L; l++) begin
                if (dif.flush) begin
                    dsp_val_q[l] <= 1'b0;
                end else if (lane_open[l]) begin
                    dsp_val_q[l] <= |pick[l];
                    if (|pick[l]) begin
                        dsp_op_q[l]    <= nxt_op[l];
                        dsp_robid_q[l] <= nxt_robid[l];
                        dsp_src_q[l]   <= nxt_src[l];
                    end
                end
            end
        end
    end

`ifdef RS_DSP_STALL_CNT_EN
    logic [L-1:0][15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            for (int l = 0; l < L; l++) begin
                if (dsp_val_q[l] && !dif.eu_rdy[l] && (stall_cnt_q[l] != 16'hFFFF)) begin
                    stall_cnt_q[l] <= stall_cnt_q[l] + 16'd1;
                end
            end
        end
    end

    assign dif.dsp_stall_cnt = stall_cnt_q;
`endif

    assign dif.dsp_val   = dsp_val_q;
    assign dif.dsp_op    = dsp_op_q;
    assign dif.dsp_robid = dsp_robid_q;
    assign dif.dsp_src   = dsp_src_q;
endmodule

// File: tb/tb_rs_dispatch_sel.sv
// tb/tb_rs_dispatch_sel.sv - scoreboard bench for rs_dispatch_sel (stall counter checks under RS_DSP_STALL_CNT_EN)
module tb_rs_dispatch_sel;
    localparam int N = 16;
    localparam int L = 4;

    typedef struct {
        int lane;
        int idx;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    sb_item_t sb[$];

    always #5 clk = ~clk;

    rs_dispatch_sel_if dif ();

    rs_dispatch_sel u_dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    function automatic logic [5:0] op_of(int k);
        return 6'(k + 1);
    endfunction

    function automatic logic [4:0] robid_of(int k);
        return 5'((3 * k + 1) % 32);
    endfunction

    function automatic logic [63:0] src_of(int k);
        logic [31:0] v0;
        logic [31:0] v1;
        v0 = 32'hA500_0000 | 32'(k);
        v1 = 32'h5A00_0000 ^ (32'(k) << 4);
        return {v1, v0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor handshakes against the scoreboard, then model the RS dropping
    // ety_rdy for freed entries just after the edge.
    task automatic tick();
        logic [N-1:0] freed;
        freed = '0;
        if (dif.flush) begin
            sb.delete();
        end else begin
            for (int l = 0; l < L; l++) begin
                if (dif.dsp_val[l] && dif.eu_rdy[l]) begin
                    int k;
                    k = -1;
                    for (int q = 0; q < sb.size(); q++) begin
                        if (sb[q].lane == l) begin
                            k = q;
                            break;
                        end
                    end
                    if (k < 0) begin
                        chk("sb_unexpected", 64'(l), 64'hFF);
                    end else begin
                        chk("sb_robid", 64'(dif.dsp_robid[l]), 64'(robid_of(sb[k].idx)));
                        chk("sb_op",    64'(dif.dsp_op[l]),    64'(op_of(sb[k].idx)));
                        chk("sb_src",   64'(dif.dsp_src[l]),   src_of(sb[k].idx));
                        sb.delete(k);
                    end
                end
            end
        end
        for (int l = 0; l < L; l++) begin
            freed = freed | dif.rs_free_ety[l];
        end
        @(posedge clk);
        #1;
        dif.ety_rdy = dif.ety_rdy & ~freed;
        #1;
    endtask

    task automatic alloc_one(input int k, input int lane);
        dif.ety_fu[k]  = 2'(lane);
        dif.alloc_ety  = 16'(1) << k;
        #1;
        tick();
        dif.alloc_ety  = '0;
    endtask

    initial begin
        rst           = 1'b0;
        dif.flush     = 1'b0;
        dif.alloc_ety = '0;
        dif.ety_rdy   = '1;
        dif.ety_fu    = '0;
        dif.eu_rdy    = '1;
        for (int i = 0; i < N; i++) begin
            dif.ety_op[i]    = op_of(i);
            dif.ety_robid[i] = robid_of(i);
            dif.ety_v[i]     = src_of(i);
        end

        // reset holds everything quiet even with all entries ready
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst_val",  64'(dif.dsp_val), 64'h0);
            chk("rst_free", dif.rs_free_ety,  64'h0);
            chk("rst_rob",  64'(dif.dsp_robid), 64'h0);
        end
        dif.ety_rdy = '0;
        rst = 1'b1;
        @(posedge clk);
        #2;

        // age order 5, 2, 9 on lane 1
        alloc_one(5, 1);
        alloc_one(2, 1);
        alloc_one(9, 1);
        dif.ety_rdy = 16'h0224;
        sb.push_back('{1, 5});
        sb.push_back('{1, 2});
        sb.push_back('{1, 9});
        #1;
        chk("age_free0", 64'(dif.rs_free_ety[1]), 64'h0020);
        tick();
        chk("age_free1", 64'(dif.rs_free_ety[1]), 64'h0004);
        chk("age_val1",  64'(dif.dsp_val[1]), 64'h1);
        tick();
        chk("age_free2", 64'(dif.rs_free_ety[1]), 64'h0200);
        tick();
        chk("age_free3", 64'(dif.rs_free_ety[1]), 64'h0);
        tick();
        chk("age_idle", 64'(dif.dsp_val), 64'h0);

        // simultaneous allocation: lower index is older
        dif.ety_fu[0] = 2'd0;
        dif.ety_fu[3] = 2'd0;
        dif.alloc_ety = 16'h0009;
        #1;
        chk("sim_nocand", dif.rs_free_ety, 64'h0);
        tick();
        dif.alloc_ety = '0;
        dif.ety_rdy   = 16'h0009;
        sb.push_back('{0, 0});
        sb.push_back('{0, 3});
        #1;
        chk("sim_free0", 64'(dif.rs_free_ety[0]), 64'h0001);
        tick();
        chk("sim_free1", 64'(dif.rs_free_ety[0]), 64'h0008);
        tick();
        tick();
        chk("sim_idle", 64'(dif.dsp_val), 64'h0);

        // backpressure on lane 2, then no-bubble refill
        alloc_one(2, 2);
        alloc_one(4, 2);
        dif.ety_rdy = 16'h0004;
        sb.push_back('{2, 2});
        #1;
        chk("bp_free_first", 64'(dif.rs_free_ety[2]), 64'h0004);
        tick();
        dif.eu_rdy[2] = 1'b0;
        dif.ety_rdy   = 16'h0010;
        sb.push_back('{2, 4});
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_hold_rob",  64'(dif.dsp_robid[2]), 64'd7);
            chk("bp_hold_val",  64'(dif.dsp_val[2]), 64'h1);
            chk("bp_hold_free", 64'(dif.rs_free_ety[2]), 64'h0);
            tick();
        end
        dif.eu_rdy[2] = 1'b1;
        #1;
        chk("bp_refill_free", 64'(dif.rs_free_ety[2]), 64'h0010);
        tick();
        chk("bp_refill_rob", 64'(dif.dsp_robid[2]), 64'(robid_of(4)));
        chk("bp_refill_val", 64'(dif.dsp_val[2]), 64'h1);
        tick();
        tick();

        // flush kills lanes 0 and 3 and suppresses picks
        dif.ety_fu[7] = 2'd3;
        dif.eu_rdy    = '0;
        dif.ety_rdy   = 16'h0081;
        #1;
        tick();
        chk("fl_pre_val", 64'(dif.dsp_val), 64'h9);
        dif.ety_fu[6] = 2'd0;
        dif.ety_rdy   = 16'h0040;
        dif.flush     = 1'b1;
        #1;
        chk("fl_free", dif.rs_free_ety, 64'h0);
        tick();
        dif.flush  = 1'b0;
        dif.eu_rdy = '1;
        #1;
        chk("fl_val", 64'(dif.dsp_val), 64'h0);
        sb.push_back('{0, 6});
        chk("fl_after_free", 64'(dif.rs_free_ety[0]), 64'h0040);
        tick();
        tick();
        chk("fl_idle", 64'(dif.dsp_val), 64'h0);

`ifdef RS_DSP_STALL_CNT_EN
        chk("stall_l2", 64'(dif.dsp_stall_cnt[2]), 64'd3);
        chk("stall_l0", 64'(dif.dsp_stall_cnt[0]), 64'd1);
        dif.ety_rdy = 16'h0001;
        sb.push_back('{0, 0});
        #1;
        tick();
        dif.eu_rdy[0] = 1'b0;
        repeat (70000) @(posedge clk);
        #2;
        chk("stall_sat", 64'(dif.dsp_stall_cnt[0]), 64'hFFFF);
        dif.flush = 1'b1;
        @(posedge clk);
        #2;
        dif.flush = 1'b0;
        chk("stall_keep", 64'(dif.dsp_stall_cnt[0]), 64'hFFFF);
        sb.delete();
        dif.eu_rdy = '1;
        #1;
`endif

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
